soc_io_uart_tx: RTL and testbench
=================================

# soc_io_uart_tx

Memory-mapped UART transmitter that responds to core load/store accesses falling in the `IO_START..IO_END` window. It is the responder side of the core's M-stage data-memory interface, sitting beside the data ROM/RAM in the SoC top. It is enabled by the memory mapper's `io_en` and fed by the SoC pipe register, exactly like the data RAM. Stored bytes are buffered in a FIFO and serialised 8N1 on `o_uart_tx`.

## Interface
- `XLEN`, default `` `XLEN_64b ``: bus width is `1<<(XLEN+4)` bits.
- `FIFO_DEPTH`, default 8: TX FIFO entries; power of two, minimum 2.
- `CLKS_PER_BIT`, default 16: reset value of the divisor, plus 1.

Ports:
- `i_clk`, in, 1: clock.
- `i_rst`, in, 1: reset, asynchronous, active-high.
- `i_clk_en`, in, 1: global step enable; all state advances only when it is 1.
- `i_io_en`, in, 1: address lies in the IO window (from the mapper).
- `i_mem_write`, in, 1: store in the M stage.
- `i_mem_addr`, in, XLEN-bit: translated offset into the IO window.
- `i_mem_data`, in, XLEN-bit: store data.
- `o_mem_data`, out, XLEN-bit: load data; combinational.
- `o_uart_tx`, out, 1: serial line; idles high.
- `o_irq`, out, 1: TX-done interrupt (see Configuration).

## Operation
- Register map is decoded on `i_mem_addr[4:3]`; bits `[2:0]` are ignored. Offsets of 0x20 and above read 0 and ignore writes.
  - 0x00 TXDATA: write pushes `i_mem_data[7:0]`. Reads 0.
  - 0x08 STATUS (read-only except bit 3):
    - bit 0: full.
    - bit 1: empty.
    - bit 2: busy (FSM not IDLE).
    - bit 3: overflow, sticky; writing 1 clears it.
    - bits `[15:8]`: FIFO count.
  - 0x10 CTRL: bit 0 TXEN; bit 1 IRQEN (macro only).
  - 0x18 DIV: bits `[15:0]`; each bit lasts DIV+1 enabled cycles.
- A write takes effect on a posedge with `i_clk_en & i_io_en & i_mem_write`. Byte/half store qualifiers are not used.
- Reads have no side effects. `o_mem_data` is 0 whenever `i_io_en=0`.
- Push to a full FIFO: the byte is dropped and overflow is set. The exception is a same-edge pop, in which case the push is accepted and the count is unchanged.
- FSM states and transitions:
  - IDLE → START when TXEN=1 and the FIFO is non-empty. The FIFO is popped on the same edge.
  - START: drive 0.
  - DATA: 8 bits, LSB first; 3-bit bit index.
  - STOP: drive 1.
  - STOP → START on back-to-back frames if TXEN=1 and the FIFO is non-empty; otherwise STOP → IDLE.
- Baud counter:
  - Loads DIV on every state/bit entry and counts down to 0 on enabled cycles.
  - The DIV value is sampled at frame start; writes to DIV mid-frame apply to the next frame.
  - DIV=0 gives 1 cycle per bit.
- Clearing TXEN mid-frame lets the current frame finish; no further pop occurs.

## Timing
- Reset values: `o_uart_tx`=1, `o_irq`=0, FIFO empty, overflow=0, CTRL=0, DIV=`CLKS_PER_BIT-1`, FSM IDLE.
- With FSM IDLE and TXEN=1, a TXDATA write at enabled edge N produces:
  - pop and `o_uart_tx`=0 after edge N+1.
  - a full frame of 10×(DIV+1) enabled cycles.
- `i_clk_en=0` freezes all state; the line holds its value.
- `o_uart_tx` is registered and glitch-free.
- `i_rst` asserted mid-frame: the line returns to 1 immediately (async) and the FIFO contents are lost.

## Configuration
- `SOC_UART_TX_IRQ_EN` defined:
  - CTRL bit 1 is IRQEN.
  - `o_irq` is registered, equal to IRQEN & empty & !busy.
  - It is level-sensitive and clears on the next push or when IRQEN=0.
- Undefined: `o_irq` is tied to 0, and CTRL bit 1 reads 0 and ignores writes.

## Structure
- A shared package/defines header holds:
  - the register offsets (`UART_TXDATA_OFF`, `UART_STATUS_OFF`, `UART_CTRL_OFF`, `UART_DIV_OFF`);
  - STATUS/CTRL bit indices;
  - the FSM state encodings (IDLE/START/DATA/STOP).
- Sub-module `soc_sync_fifo`: parameterised width/depth, push/pop/full/empty/count. It is reusable for a future RX block.

## Test plan
- Reset: `o_uart_tx`=1, STATUS reads 0x2 (empty), DIV reads 15.
- DIV=3, TXEN=1, write 0xA5: line shows 0,1,0,1,0,0,1,0,1,1, each level for 4 enabled cycles; busy=1 during the frame, 0 afterwards.
- TXEN=0, write 9 bytes with depth 8: STATUS full=1, overflow=1, count=8. Write 0x08 to STATUS: overflow clears.
- Two bytes 0x55,0x0F queued with DIV=0: back-to-back frames with no idle gap between the stop bit and the next start bit.
- `i_clk_en` toggling every other cycle: frame duration doubles in `i_clk` cycles while the bit pattern is unchanged.
- Macro on, IRQEN=1: `o_irq` rises one cycle after STOP→IDLE and clears after the next TXDATA write. Assert `i_rst` mid-DATA: line=1 and FIFO empty immediately.

Source files
------------

// File: rtl/soc_io_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS/CTRL bit positions, FSM encoding and the bus-width selector.
`ifndef XLEN_64b
`define XLEN_64b 2
`endif

package soc_io_uart_tx_pkg;

  localparam logic [4:0] UART_TXDATA_OFF = 5'h00;
  localparam logic [4:0] UART_STATUS_OFF = 5'h08;
  localparam logic [4:0] UART_CTRL_OFF   = 5'h10;
  localparam logic [4:0] UART_DIV_OFF    = 5'h18;

  localparam int UART_ST_FULL    = 0;
  localparam int UART_ST_EMPTY   = 1;
  localparam int UART_ST_BUSY    = 2;
  localparam int UART_ST_OVF     = 3;
  localparam int UART_ST_CNT_LSB = 8;

  localparam int UART_CTRL_TXEN  = 0;
  localparam int UART_CTRL_IRQEN = 1;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } uart_tx_state_e;

  // Registers are 8 bytes apart; only address bits [4:3] select one.
  function automatic logic [1:0] uart_reg_sel(input logic [4:0] off);
    return off[4:3];
  endfunction

endpackage

// File: rtl/soc_sync_fifo.sv
// Single-clock FIFO with push/pop/full/empty/count; a push while full is only
// accepted when a pop happens on the same edge.
module soc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, wr_q;
  logic [AW:0]      cnt_q;
  logic             push_ok, pop_ok;

  assign o_full  = (cnt_q == (AW+1)'(DEPTH));
  assign o_empty = (cnt_q == '0);
  assign o_count = cnt_q;
  assign o_data  = mem_q[rd_q];
  assign pop_ok  = i_pop & ~o_empty;
  assign push_ok = i_push & (~o_full | pop_ok);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_q] <= i_data;
  end

endmodule

// File: rtl/soc_io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO on the core's IO window.
// Define SOC_UART_TX_IRQ_EN to enable the CTRL.IRQEN bit and the TX-done interrupt.
//   state | meaning
//   IDLE  | line high, waiting for TXEN and a queued byte
//   START | start bit (0)
//   DATA  | 8 data bits, LSB first
//   STOP  | stop bit (1); may chain straight into the next START
module soc_io_uart_tx
  import soc_io_uart_tx_pkg::*;
#(
  parameter int XLEN         = `XLEN_64b,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clk_en,
  input  logic                     i_io_en,
  input  logic                     i_mem_write,
  input  logic [(1<<(XLEN+4))-1:0] i_mem_addr,
  input  logic [(1<<(XLEN+4))-1:0] i_mem_data,
  output logic [(1<<(XLEN+4))-1:0] o_mem_data,
  output logic                     o_uart_tx,
  output logic                     o_irq
);
  localparam int W  = 1 << (XLEN + 4);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [1:0] SEL_TXDATA = uart_reg_sel(UART_TXDATA_OFF);
  localparam logic [1:0] SEL_STATUS = uart_reg_sel(UART_STATUS_OFF);
  localparam logic [1:0] SEL_CTRL   = uart_reg_sel(UART_CTRL_OFF);
  localparam logic [1:0] SEL_DIV    = uart_reg_sel(UART_DIV_OFF);

  logic           in_win, wr_en, busy, fsm_pop;
  logic [1:0]     sel;
  logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]     fifo_data;
  logic [CW-1:0]  fifo_count;
  logic           txen_q, txen_d, ovf_q, ovf_d;
  logic [15:0]    div_q, div_d, div_frame_q, div_frame_d, baud_q, baud_d;
  uart_tx_state_e state_q, state_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shreg_q, shreg_d;
  logic           tx_q, tx_d;
  logic           unused_bits;

  assign unused_bits = ^{i_mem_addr[2:0], i_mem_data[W-1:16]};
  assign in_win    = (i_mem_addr[W-1:5] == '0);
  assign sel       = uart_reg_sel(i_mem_addr[4:0]);
  assign wr_en     = i_clk_en & i_io_en & i_mem_write & in_win;
  assign busy      = (state_q != TX_IDLE);
  assign fifo_pop  = i_clk_en & fsm_pop;
  assign fifo_push = wr_en & (sel == SEL_TXDATA) & (~fifo_full | fifo_pop);
  assign o_uart_tx = tx_q;

  soc_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (fifo_push),
    .i_pop   (fifo_pop),
    .i_data  (i_mem_data[7:0]),
    .o_data  (fifo_data),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  always_comb begin
    txen_d = txen_q;
    ovf_d  = ovf_q;
    div_d  = div_q;
    if (wr_en && sel == SEL_TXDATA && fifo_full && !fifo_pop) ovf_d = 1'b1;
    if (wr_en && sel == SEL_STATUS && i_mem_data[UART_ST_OVF]) ovf_d = 1'b0;
    if (wr_en && sel == SEL_CTRL) txen_d = i_mem_data[UART_CTRL_TXEN];
    if (wr_en && sel == SEL_DIV)  div_d  = i_mem_data[15:0];
  end

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    div_frame_d = div_frame_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    tx_d        = tx_q;
    fsm_pop     = 1'b0;
    case (state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (txen_q && !fifo_empty) begin
          fsm_pop     = 1'b1;
          state_d     = TX_START;
          tx_d        = 1'b0;
          baud_d      = div_q;
          div_frame_d = div_q;
          shreg_d     = fifo_data;
        end
      end
      TX_START: begin
        if (baud_q == '0) begin
          state_d = TX_DATA;
          bit_d   = '0;
          tx_d    = shreg_q[0];
          baud_d  = div_frame_q;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      TX_DATA: begin
        if (baud_q == '0) begin
          baud_d = div_frame_q;
          if (bit_q == 3'd7) begin
            state_d = TX_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      TX_STOP: begin
        if (baud_q != '0) begin
          baud_d = baud_q - 16'd1;
        end else if (txen_q && !fifo_empty) begin
          // Chain the next frame with no idle gap; DIV is re-sampled here.
          fsm_pop     = 1'b1;
          state_d     = TX_START;
          tx_d        = 1'b0;
          baud_d      = div_q;
          div_frame_d = div_q;
          shreg_d     = fifo_data;
        end else begin
          state_d = TX_IDLE;
          tx_d    = 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      txen_q      <= 1'b0;
      ovf_q       <= 1'b0;
      div_q       <= 16'(CLKS_PER_BIT - 1);
      div_frame_q <= 16'(CLKS_PER_BIT - 1);
      baud_q      <= '0;
      state_q     <= TX_IDLE;
      bit_q       <= '0;
      shreg_q     <= '0;
      tx_q        <= 1'b1;
    end else if (i_clk_en) begin
      txen_q      <= txen_d;
      ovf_q       <= ovf_d;
      div_q       <= div_d;
      div_frame_q <= div_frame_d;
      baud_q      <= baud_d;
      state_q     <= state_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      tx_q        <= tx_d;
    end
  end

`ifdef SOC_UART_TX_IRQ_EN
  logic irqen_q, irqen_d, irq_q;

  always_comb begin
    irqen_d = irqen_q;
    if (wr_en && sel == SEL_CTRL) irqen_d = i_mem_data[UART_CTRL_IRQEN];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      irqen_q <= 1'b0;
      irq_q   <= 1'b0;
    end else if (i_clk_en) begin
      irqen_q <= irqen_d;
      irq_q   <= irqen_q & fifo_empty & ~busy;
    end
  end

  assign o_irq = irq_q;
`else
  assign o_irq = 1'b0;
`endif

  always_comb begin
    o_mem_data = '0;
    if (i_io_en && in_win) begin
      if (sel == SEL_STATUS) begin
        o_mem_data[UART_ST_FULL]             = fifo_full;
        o_mem_data[UART_ST_EMPTY]            = fifo_empty;
        o_mem_data[UART_ST_BUSY]             = busy;
        o_mem_data[UART_ST_OVF]              = ovf_q;
        o_mem_data[UART_ST_CNT_LSB +: 8]     = 8'(fifo_count);
      end else if (sel == SEL_CTRL) begin
        o_mem_data[UART_CTRL_TXEN] = txen_q;
`ifdef SOC_UART_TX_IRQ_EN
        o_mem_data[UART_CTRL_IRQEN] = irqen_q;
`endif
      end else if (sel == SEL_DIV) begin
        o_mem_data[15:0] = div_q;
      end
    end
  end

endmodule

// File: tb/tb_soc_io_uart_tx.sv
// Directed self-checking bench for soc_io_uart_tx (default 64-bit bus, depth 8).
module tb_soc_io_uart_tx;
  logic        clk = 1'b0;
  logic        rst, clk_en, io_en, mem_write;
  logic [63:0] mem_addr, mem_data, rdata;
  logic        uart_tx, irq;
  int          n_cmp = 0;
  int          n_err = 0;

`ifdef SOC_UART_TX_IRQ_EN
  localparam logic [63:0] EXP_CTRL = 64'd3;
  localparam logic        EXP_IRQ  = 1'b1;
`else
  localparam logic [63:0] EXP_CTRL = 64'd1;
  localparam logic        EXP_IRQ  = 1'b0;
`endif

  soc_io_uart_tx dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_clk_en    (clk_en),
    .i_io_en     (io_en),
    .i_mem_write (mem_write),
    .i_mem_addr  (mem_addr),
    .i_mem_data  (mem_data),
    .o_mem_data  (rdata),
    .o_uart_tx   (uart_tx),
    .o_irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [63:0] a, input logic [63:0] d);
    io_en = 1'b1; mem_write = 1'b1; mem_addr = a; mem_data = d;
    @(posedge clk); #1;
    io_en = 1'b0; mem_write = 1'b0;
  endtask

  task automatic bus_rd(input logic [63:0] a, output logic [63:0] d);
    io_en = 1'b1; mem_write = 1'b0; mem_addr = a;
    #1 d = rdata;
    io_en = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    logic [63:0] st;
    logic        ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      bus_rd(64'h08, st);
      if (st[1] && !st[2]) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk(tag, {63'd0, ok}, 64'd1);
  endtask

  // Each frame bit repeated n times, start bit in bit 0.
  function automatic logic [63:0] stretch(input logic [9:0] fb, input int n);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 10 * n; i++) r[i] = fb[i / n];
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d, cap, exp;
    logic [9:0]  fb;
    logic        busy_all;

    rst = 1'b1; clk_en = 1'b1; io_en = 1'b0; mem_write = 1'b0;
    mem_addr = '0; mem_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_tx", {63'd0, uart_tx}, 64'd1);
    chk("rst_irq", {63'd0, irq}, 64'd0);
    bus_rd(64'h08, d); chk("rst_status", d, 64'h2);
    bus_rd(64'h18, d); chk("rst_div", d, 64'd15);
    bus_rd(64'h10, d); chk("rst_ctrl", d, 64'd0);
    io_en = 1'b0; mem_addr = 64'h08;
    #1 chk("rd_no_io_en", rdata, 64'd0);
    bus_rd(64'h28, d); chk("rd_out_of_window", d, 64'd0);

    // Single frame 0xA5 at DIV=3
    bus_wr(64'h18, 64'd3);
    bus_wr(64'h10, 64'd1);
    bus_wr(64'h00, 64'hA5);
    @(posedge clk); #1;
    io_en = 1'b1; mem_write = 1'b0; mem_addr = 64'h08;
    cap = '0; busy_all = 1'b1;
    for (int k = 0; k < 40; k++) begin
      cap[k] = uart_tx;
      if (k % 4 == 2) busy_all = busy_all & rdata[2];
      @(posedge clk); #1;
    end
    fb = {1'b1, 8'hA5, 1'b0};
    chk("a5_frame", cap, stretch(fb, 4));
    chk("a5_busy_during", {63'd0, busy_all}, 64'd1);
    chk("a5_busy_after", {63'd0, rdata[2]}, 64'd0);
    chk("a5_tx_after", {63'd0, uart_tx}, 64'd1);
    io_en = 1'b0;

    // Overflow with TXEN=0
    bus_wr(64'h10, 64'd0);
    for (int i = 0; i < 9; i++) bus_wr(64'h00, 64'h10 + 64'(i));
    bus_rd(64'h08, d); chk("ovf_status", d, 64'h0809);
    bus_wr(64'h08, 64'h08);
    bus_rd(64'h08, d); chk("ovf_cleared", d, 64'h0801);
    bus_rd(64'h0D, d); chk("status_low_bits_ignored", d, 64'h0801);
    bus_wr(64'h38, 64'd0);
    bus_rd(64'h18, d); chk("wr_out_of_window", d, 64'd3);
    bus_rd(64'h00, d); chk("txdata_reads_0", d, 64'd0);
    bus_wr(64'h18, 64'd0);
    bus_wr(64'h10, 64'd1);
    wait_idle(300, "drain_done");

    // Back-to-back 0x55, 0x0F at DIV=0
    bus_wr(64'h10, 64'd0);
    bus_wr(64'h00, 64'h55);
    bus_wr(64'h00, 64'h0F);
    bus_wr(64'h10, 64'd1);
    @(posedge clk); #1;
    cap = '0;
    for (int k = 0; k < 21; k++) begin
      cap[k] = uart_tx;
      @(posedge clk); #1;
    end
    exp = {43'd0, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b1, 8'h55, 1'b0};
    chk("b2b_frames", cap, exp);
    wait_idle(50, "b2b_done");

    // Clock enable toggling: DIV=1 doubles to 4 clk cycles per bit
    bus_wr(64'h18, 64'd1);
    bus_wr(64'h00, 64'h3C);
    cap = '0;
    for (int j = 0; j < 44; j++) begin
      clk_en = (j % 2 == 1);
      @(posedge clk); #1;
      cap[j] = uart_tx;
    end
    clk_en = 1'b1;
    fb = {1'b1, 8'h3C, 1'b0};
    exp = '0;
    for (int j = 0; j < 44; j++) exp[j] = (j == 0 || j > 40) ? 1'b1 : fb[(j - 1) / 4];
    chk("clk_en_frame", cap, exp);
    wait_idle(10, "clk_en_done");

    // IRQEN / interrupt behaviour
    bus_wr(64'h18, 64'd0);
    bus_wr(64'h10, 64'd3);
    bus_rd(64'h10, d); chk("ctrl_irqen", d, EXP_CTRL);
    repeat (2) begin @(posedge clk); #1; end
    chk("irq_idle_empty", {63'd0, irq}, {63'd0, EXP_IRQ});
    bus_wr(64'h00, 64'h81);
    @(posedge clk); #1;
    chk("irq_clr_on_push", {63'd0, irq}, 64'd0);
    repeat (10) begin @(posedge clk); #1; end
    chk("irq_at_stop_exit", {63'd0, irq}, 64'd0);
    chk("tx_idle_after_81", {63'd0, uart_tx}, 64'd1);
    @(posedge clk); #1;
    chk("irq_rise", {63'd0, irq}, {63'd0, EXP_IRQ});

    // Reset asserted mid-DATA
    bus_wr(64'h00, 64'h00);
    bus_wr(64'h00, 64'h7E);
    chk("irq_clr_next_write", {63'd0, irq}, 64'd0);
    @(posedge clk); #1;
    chk("pre_rst_tx_low", {63'd0, uart_tx}, 64'd0);
    io_en = 1'b1; mem_write = 1'b0; mem_addr = 64'h08;
    #1 chk("pre_rst_fifo_count", rdata, 64'h0104);
    #1 rst = 1'b1;
    #1 chk("rst_async_tx", {63'd0, uart_tx}, 64'd1);
    chk("rst_async_status", rdata, 64'h2);
    chk("rst_async_irq", {63'd0, irq}, 64'd0);
    io_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
